// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the multi-cycle EX-stage divider.
package div_unit_pkg;

  localparam int DivWidth   = 32;
  localparam int StallEX    = 3;
  localparam int StallWidth = 6;

  typedef logic [StallWidth-1:0] StallBus;

  typedef enum logic [1:0] {
    DivIdle = 2'b00,
    DivBusy = 2'b01,
    DivDone = 2'b10
  } divState_e;

  // Two's complement negation when neg is set; wraps mod 2^DivWidth.
  function automatic logic [DivWidth-1:0] condNeg(input logic [DivWidth-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left and trial-subtract the divisor.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DivWidth
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // The shifted partial remainder needs one extra bit; the borrow decides the quotient bit.
  always_comb begin
    w_shifted = {rem_in, quo_in[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, divisor};
    w_borrow  = w_diff[WIDTH];
    rem_out   = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    quo_out   = {quo_in[WIDTH-2:0], ~w_borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for EX; requests a stall while dividing and
// holds its result in DONE until the stall bus lets EX advance.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH    = DivWidth,
  parameter int STALL_EX = StallEX
) (
  input  logic             clk,
  input  logic             rst,
  input  StallBus          stall,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stallreq_for_ex,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CntW = $clog2(WIDTH);

  divState_e        r_state;
  divState_e        w_nextState;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_negQuo;
  logic             r_negRem;
  logic [WIDTH-1:0] w_remStep;
  logic [WIDTH-1:0] w_quoStep;
  logic [WIDTH-1:0] w_absDividend;
  logic [WIDTH-1:0] w_absDivisor;
  logic             w_divZero;
  logic             w_lastStep;

  assign w_absDividend = condNeg(dividend, signed_op & dividend[WIDTH-1]);
  assign w_absDivisor  = condNeg(divisor, signed_op & divisor[WIDTH-1]);
  assign w_divZero     = (divisor == '0);
  assign w_lastStep    = (r_count == CntW'(WIDTH - 1));
  assign quotient      = r_quotient;
  assign remainder     = r_remainder;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_divisor),
    .rem_out (w_remStep),
    .quo_out (w_quoStep)
  );

  // State register; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= DivIdle;
    else      r_state <= w_nextState;
  end

  // Next state plus the combinational stall request, which rises in the accept cycle itself.
  always_comb begin
    w_nextState     = r_state;
    ready           = (r_state == DivDone);
    stallreq_for_ex = start & (r_state != DivDone);
    case (r_state)
      DivIdle: if (start) w_nextState = w_divZero ? DivDone : DivBusy;
      DivBusy: begin
        if (!start)          w_nextState = DivIdle;
        else if (w_lastStep) w_nextState = DivDone;
      end
      DivDone: if (!start || !stall[STALL_EX]) w_nextState = DivIdle;
      default: w_nextState = DivIdle;
    endcase
  end

  // Operand capture, iteration, sign fixup into the result registers, and abort clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_negQuo    <= 1'b0;
      r_negRem    <= 1'b0;
    end else begin
      case (r_state)
        DivIdle: begin
          if (start) begin
            r_quo     <= w_absDividend;
            r_rem     <= '0;
            r_divisor <= w_absDivisor;
            r_count   <= '0;
            r_negQuo  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_negRem  <= signed_op & dividend[WIDTH-1];
            if (w_divZero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
            end
          end
        end
        DivBusy: begin
          if (!start) begin
            r_quotient  <= '0;
            r_remainder <= '0;
          end else begin
            r_rem   <= w_remStep;
            r_quo   <= w_quoStep;
            r_count <= r_count + 1'b1;
            if (w_lastStep) begin
              r_quotient  <= condNeg(w_quoStep, r_negQuo);
              r_remainder <= condNeg(w_remStep, r_negRem);
            end
          end
        end
        DivDone: begin
          if (!start) begin
            r_quotient  <= '0;
            r_remainder <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results, a negedge
// monitor pops and compares whenever ready rises.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  StallBus     stall;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stallreq_for_ex;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  logic prevReady   = 1'b0;

  div_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .start           (start),
    .signed_op       (signed_op),
    .dividend        (dividend),
    .divisor         (divisor),
    .stallreq_for_ex (stallreq_for_ex),
    .ready           (ready),
    .quotient        (quotient),
    .remainder       (remainder)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each rising ready pops one expected result and compares it.
  always @(negedge clk) begin
    if (ready && !prevReady) begin
      if (sb.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected ready: got q=0x%08h r=0x%08h, expected no result", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, " quotient"}, quotient, e.q);
        checkOutput({e.name, " remainder"}, remainder, e.r);
      end
    end
    prevReady <= ready;
  end

  // Issue one divide (called just after a posedge), track latency and stall request, then retire it.
  task automatic applyStimulus(input bit so, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input int expLat, input int holdCycles, input string name);
    exp_t e;
    int   doneCyc;
    int   stallCnt;
    e.q = expQ;
    e.r = expR;
    e.name = name;
    sb.push_back(e);
    start     = 1'b1;
    signed_op = so;
    dividend  = a;
    divisor   = b;
    doneCyc   = -1;
    stallCnt  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (ready) begin
        doneCyc = k;
        break;
      end
      if (stallreq_for_ex) stallCnt++;
    end
    checkOutput({name, " latency"}, doneCyc, expLat);
    checkOutput({name, " stallreq cycles"}, stallCnt, expLat);
    checkOutput({name, " stallreq in done"}, {31'd0, stallreq_for_ex}, 32'd0);
    if (holdCycles > 0) begin
      stall[StallEX] = 1'b1;
      for (int h = 0; h < holdCycles; h++) begin
        @(negedge clk);
        checkOutput({name, " hold ready"}, {31'd0, ready}, 32'd1);
        checkOutput({name, " hold quotient"}, quotient, expQ);
        checkOutput({name, " hold remainder"}, remainder, expR);
        checkOutput({name, " hold stallreq"}, {31'd0, stallreq_for_ex}, 32'd0);
      end
      stall[StallEX] = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (holdCycles > 0) begin
      @(negedge clk);
      checkOutput({name, " release to idle"}, {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    rst       = 1'b0;
    stall     = '0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", {31'd0, ready}, 32'd0);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset stallreq", {31'd0, stallreq_for_ex}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 3, "divu 100/7");
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0, "div -7/2");
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 0, "div 7/-2");
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 0, "div min/-1");
    applyStimulus(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 0, "divu 5/0");

    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy reset ready", {31'd0, ready}, 32'd0);
    checkOutput("busy reset quotient", quotient, 32'd0);
    checkOutput("busy reset remainder", remainder, 32'd0);
    checkOutput("busy reset stallreq", {31'd0, stallreq_for_ex}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0, "divu 9/3");

    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort stallreq", {31'd0, stallreq_for_ex}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort no ready", {31'd0, ready}, 32'd0);
    end
    checkOutput("abort quotient cleared", quotient, 32'd0);
    checkOutput("abort remainder cleared", remainder, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 33, 0, "divu 8/2");
    applyStimulus(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, 0, "divu 9/4");

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
